rr_port_merge: RTL and testbench
================================

// Module: rr_port_merge
//
// PURPOSE
// - Merges NUM_CH valid/ready input channels into one output stream through a round-robin
//   arbiter and a DEPTH-entry output FIFO.
// - Each output beat carries its source channel index.
// - Sits between per-port producers (one per declared port group) and a single shared consumer.
// - Successor of the single-channel port stage: generalised in channel count, width and depth;
//   adds fair arbitration and buffering.
//
// PARAMETERS
// - NUM_CH   4   number of input channels, >= 2
// - DATA_W   8   data width per channel, >= 1
// - DEPTH    4   output FIFO entries, power of 2, >= 2
// - CH_W     $clog2(NUM_CH)   derived: channel index width, not overridable
// - CNT_W    $clog2(DEPTH+1)  derived: occupancy width, not overridable
//
// PORTS
// - clk        input   1              rising-edge clock
// - rst        input   1              asynchronous reset, active-high
// - in_valid   input   NUM_CH         per-channel valid
// - in_data    input   NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
// - in_ready   output  NUM_CH         per-channel ready; combinational
// - out_valid  output  1              FIFO non-empty
// - out_data   output  DATA_W         head-of-FIFO data
// - out_ch     output  CH_W           source channel of head entry
// - out_ready  input   1              consumer accept
// - count      output  CNT_W          FIFO occupancy, 0..DEPTH
//
// BEHAVIOUR
// - Reset (async assert, synchronous release): all state clears to 0.
//   - out_valid=0, out_data=0, out_ch=0, count=0; rr pointer=0, wr_ptr=rd_ptr=0.
//   - in_ready forced 0 while rst=1.
// - Arbitration (combinational):
//   - Search in_valid from index ptr upward, wrapping at NUM_CH.
//   - The first set bit is the grant. At most one grant per cycle.
// - in_ready[i] = ~rst & ~full & grant[i].
//   - No combinational path from out_ready to in_ready.
// - Push: a granted channel with in_valid=1 and in_ready=1 writes {ch, data} at wr_ptr.
//   - The rr pointer then moves to (granted index + 1) mod NUM_CH.
//   - With no push, the pointer holds.
// - Pop: out_valid & out_ready advances rd_ptr.
//   - out_data and out_ch are driven from the FIFO array at rd_ptr (registered storage).
// - Latency: a beat accepted in cycle N is visible on out_* in cycle N+1.
//   - This holds even when the FIFO was empty (no bypass).
// - Occupancy: count += push - pop.
//   - Push and pop in the same cycle leave count unchanged.
//   - full = (count==DEPTH); empty = (count==0).
// - Full: all in_ready=0. A pop while full frees space for the next cycle, not the same cycle.
// - Empty: out_valid=0. An out_ready assertion has no effect.
// - Pointer wrap: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
// - Reset mid-stream: FIFO contents are discarded, out_valid drops immediately (async), and
//   no beat is emitted after release until a new push.
// - Producers must hold in_data/in_valid stable until accepted.
//   - Dropping valid without acceptance is tolerated; the arbiter simply re-evaluates.
//
// TESTING
// - Reset: assert rst mid-traffic with count=3 -> out_valid=0, count=0 and in_ready=0 at once;
//   after release the first pop is the first post-reset push.
// - Fairness: all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,...
//   and each channel gets 1 grant per 4 cycles.
// - Sparse: only ch2 and ch0 valid, ptr=1 -> ch2 granted first, then ch0, then ch2.
// - Full/backpressure: out_ready=0, ch1 streams 0x11..0x15 -> 4 accepted, count=4, in_ready=0;
//   one pop of 0x11 -> in_ready[1]=1 the next cycle and 0x15 is accepted.
// - Simultaneous: count=2, push and pop in the same cycle -> count stays 2 and data order is
//   preserved across the wr/rd pointer wrap (more than 8 beats total).
// - Latency: FIFO empty, push 0xA5 on ch3 in cycle N -> out_valid=1, out_data=0xA5,
//   out_ch=3 in cycle N+1.

Source files
------------

// File: rtl/rr_port_merge.sv
// Round-robin merge of NUM_CH valid/ready channels into one stream through a
// DEPTH-entry FIFO; each output beat is tagged with its source channel index.
module rr_port_merge #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CH_W:0]   LP_NCH  = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LP_LAST = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]   r_ptr;
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [CH_W-1:0]   r_mem_ch   [DEPTH];

  logic              w_full;
  logic              w_empty;
  logic              w_found;
  logic              w_push;
  logic              w_pop;
  logic [CH_W-1:0]   w_gidx;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [CH_W:0]     w_sum;
  logic [NUM_CH-1:0] w_grant;

  // Handshake: a beat moves when valid and ready are both high on a rising edge.
  // in_ready depends only on the grant and fullness, never on out_ready.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, r_ptr} + (CH_W + 1)'(k);
      if (w_sum >= LP_NCH) w_sum = w_sum - LP_NCH;
      if (!w_found && in_valid[w_sum[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = (rst || w_full) ? '0 : w_grant;
  assign w_push    = w_found & ~w_full & ~rst;
  assign w_pop     = ~w_empty & out_ready;
  assign w_ptr_nxt = (w_gidx == LP_LAST) ? '0 : w_gidx + CH_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_ch[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr] <= in_data[w_gidx*DATA_W +: DATA_W];
        r_mem_ch[r_wr]   <= w_gidx;
        r_wr             <= r_wr + AW'(1);
        r_ptr            <= w_ptr_nxt;
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // No bypass: the head is always read from storage, so a push shows one cycle later.
  assign out_valid = ~w_empty;
  assign out_data  = r_mem_data[r_rd];
  assign out_ch    = r_mem_ch[r_rd];
  assign count     = r_count;

endmodule

// File: tb/tb_rr_port_merge.sv
// Directed bench for rr_port_merge: stimulus pushes hand-computed beats into a
// queue, a negedge monitor pops and compares every beat the DUT hands out.
module tb_rr_port_merge;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;
  localparam int EW     = CH_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
  logic [CNT_W-1:0]         count;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  rr_port_merge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=0x%0h expected=none", {out_ch, out_data});
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_beat", 32'({out_ch, out_data}), 32'(mon_e));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
    in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_beat(input int ch, input logic [DATA_W-1:0] d);
    exp_q.push_back({CH_W'(ch), d});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (count == 0 && exp_q.size() == 0) break;
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  int sp_g [3] = '{2, 0, 2};

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b0;

    // reset state, in_ready held low while rst even with all valid
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    step();
    rst      = 1'b0;
    in_valid = '0;

    // latency: empty FIFO, push 0xA5 on ch3 in cycle N, visible in N+1
    step();
    in_valid  = 4'b1000;
    set_data(3, 8'hA5);
    out_ready = 1'b1;
    @(negedge clk);
    check("lat_in_ready",  32'(in_ready),  32'b1000);
    check("lat_empty",     32'(out_valid), 32'd0);
    expect_beat(3, 8'hA5);
    step();
    in_valid = '0;
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data",  32'(out_data),  32'hA5);
    check("lat_out_ch",    32'(out_ch),    32'd3);
    drain();

    // fairness: all valid, pointer at 0 -> grants 0,1,2,3,0,1,2,3
    step();
    for (int c = 0; c < NUM_CH; c++) set_data(c, 8'(8'h40 + c));
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
      expect_beat(k % 4, 8'(8'h40 + (k % 4)));
      step();
    end
    in_valid = '0;
    drain();

    // sparse: ch0 push moves the pointer to 1, then ch0+ch2 -> 2,0,2
    step();
    in_valid = 4'b0001;
    set_data(0, 8'h01);
    @(negedge clk);
    check("sparse_setup", 32'(in_ready), 32'b0001);
    expect_beat(0, 8'h01);
    step();
    in_valid = 4'b0101;
    set_data(0, 8'h20);
    set_data(2, 8'h22);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sparse_in_ready", 32'(in_ready), 32'(1 << sp_g[k]));
      expect_beat(sp_g[k], (sp_g[k] == 2) ? 8'h22 : 8'h20);
      step();
    end
    in_valid = '0;
    drain();

    // full / backpressure: ch1 streams 0x11..0x15 with out_ready low
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_data(1, 8'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_fill_ready", 32'(in_ready), 32'b0010);
      expect_beat(1, 8'(8'h11 + i));
      step();
      set_data(1, 8'(8'h12 + i));
    end
    @(negedge clk);
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_same_cycle", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("full_after_pop_count", 32'(count),    32'd3);
    check("full_after_pop_ready", 32'(in_ready), 32'b0010);
    expect_beat(1, 8'h15);
    step();
    in_valid = '0;
    @(negedge clk);
    check("full_refill_count", 32'(count), 32'd4);
    drain();

    // simultaneous push/pop at count=2 across several pointer wraps
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_data(0, 8'h60);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("sim_fill_ready", 32'(in_ready), 32'b0001);
      expect_beat(0, 8'(8'h60 + i));
      step();
      set_data(0, 8'(8'h61 + i));
    end
    out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      @(negedge clk);
      check("sim_count",    32'(count),    32'd2);
      check("sim_in_ready", 32'(in_ready), 32'b0001);
      expect_beat(0, 8'(8'h60 + i));
      step();
      set_data(0, 8'(8'h61 + i));
    end
    in_valid = '0;
    drain();

    // reset mid-stream with count=3
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    set_data(2, 8'h30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_fill_ready", 32'(in_ready), 32'b0100);
      step();
      set_data(2, 8'(8'h31 + i));
    end
    @(negedge clk);
    check("mid_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count",     32'(count),     32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    step();
    step();
    rst      = 1'b0;
    in_valid = '0;
    @(negedge clk);
    check("post_rst_idle0", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("post_rst_idle1", 32'(out_valid), 32'd0);
    step();
    in_valid = 4'b0100;
    set_data(2, 8'h77);
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'b0100);
    expect_beat(2, 8'h77);
    step();
    in_valid = '0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    drain();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
